ppu_bg_pixel_fifo: RTL and testbench
====================================

// Module: ppu_bg_pixel_fifo
// PURPOSE
//  Background pixel FIFO between the PPU tile fetcher and the framebuffer writer.
//  Accepts one decoded tile row (8 pixels, two 2bpp plane bytes) per push.
//  Presents one 2-bit colour per pop, show-ahead.
//  Also discards the SCX fine-scroll pixels at line start so they never reach the screen.
// PARAMETERS
//  DEPTH   16  pixel slots; power of 2, >= 16
//  CNT_W   $clog2(DEPTH)+1  width of occupancy count
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-high
//  dot_en         in   1      PPU dot strobe; gates discard stepping only
//  flush          in   1      sync clear (mode change / new line / window start)
//  push_valid     in   1      fetcher offers a tile row
//  push_lo        in   8      tile plane 0 byte (bit 7 = leftmost pixel)
//  push_hi        in   8      tile plane 1 byte
//  push_xflip     in   1      1 = bit 0 is leftmost pixel
//  push_ready     out  1      count <= DEPTH-8
//  pop_en         in   1      consumer takes head pixel this clk
//  pop_color      out  2      head pixel colour, combinational from storage
//  empty          out  1      no poppable pixel
//  discard_load   in   1      load fine-scroll discard count
//  scx_fine       in   3      pixels to drop (SCX[2:0])
//  discarding     out  1      discard counter != 0
//  count          out  CNT_W  current occupancy
// BEHAVIOUR
//  Storage and pointers
//  - Circular array of DEPTH 2-bit entries.
//  - rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
//  - count is held separately, range 0..DEPTH.
//  Push
//  - Push is accepted iff push_valid && push_ready, evaluated on the pre-clock count.
//  - A same-cycle pop does not create room for the push.
//  - On an accepted push, entry wr_ptr+i (i = 0..7) gets:
//      xflip=0: {push_hi[7-i], push_lo[7-i]}
//      xflip=1: {push_hi[i], push_lo[i]}
//  - wr_ptr += 8.
//  - push_valid while not ready is ignored. The fetcher holds its data; nothing is stored.
//  Pop
//  - Pop is accepted iff pop_en && !empty; rd_ptr += 1.
//  - pop_en while empty is ignored, with no pointer or count change.
//  - pop_color = storage[rd_ptr] when !empty, else 2'b00.
//  Count update, same clk
//  - push and pop together: +7
//  - push only: +8
//  - pop only: -1
//  - count never exceeds DEPTH and never underflows.
//  Discard
//  - discard_load sets disc_cnt = scx_fine.
//  - While disc_cnt != 0 && count != 0 && dot_en: drop the head (rd_ptr+1, count-1) and disc_cnt-1.
//  - A discard step and a push in the same clk combine as for pop.
//  - empty = (count == 0) || (disc_cnt != 0), so the consumer never pops during discard.
//  - If pop_en is asserted in a discard cycle, the pop is ignored.
//  - discard_load together with a discard step: the load wins and no step occurs.
//  - scx_fine = 0 gives no discard.
//  Flush
//  - Synchronous; highest priority over push, pop, discard and discard_load in the same clk.
//  - Clears rd_ptr, wr_ptr, count and disc_cnt.
//  - Storage contents are not cleared.
//  Latency
//  - A pushed pixel is visible on pop_color and empty deasserts the clk after the push.
//  - No other pipeline stages.
//  Reset, async
//  - Pointers, count and disc_cnt = 0.
//  - Outputs: empty=1, push_ready=1, pop_color=0, discarding=0, count=0.
//  - Reset asserted mid-push or mid-discard aborts it with no residue.
// TESTING
//  1. Reset, then push lo=8'hF0 hi=8'hCC xflip=0.
//     -> next clk count=8, empty=0.
//     -> 8 pops yield colours 3,3,1,1,2,2,0,0; then empty=1.
//  2. Push lo=8'h01 hi=8'h00 xflip=1 -> first popped colour = 1, remaining seven = 0.
//  3. Push twice (count=16), then push_valid again.
//     -> push_ready=0, count stays 16.
//     -> pop+push in one clk with count=8: count=15, and the pixel order is preserved across the wrap.
//  4. count=8, discard_load scx_fine=3, dot_en every other clk, pop_en held high.
//     -> empty=1 until 3 pixels dropped; count=5.
//     -> the first popped pixel is original pixel 3.
//  5. count=12 and disc_cnt=2, assert flush with push_valid and pop_en.
//     -> next clk count=0, empty=1, discarding=0, push_ready=1; nothing stored.
//  6. Assert reset asynchronously between clk edges mid-push.
//     -> outputs at their reset values immediately.
//     -> after release, a push/pop round-trip behaves as in scenario 1.

Source files
------------

// File: rtl/ppu_bg_pixel_fifo.sv
// Background pixel FIFO: takes one 8-pixel tile row per push, hands out one
// 2-bit colour per pop (show-ahead), and silently drops SCX fine-scroll pixels.
module ppu_bg_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dot_en,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [7:0]       push_lo,
    input  logic [7:0]       push_hi,
    input  logic             push_xflip,
    output logic             push_ready,
    input  logic             pop_en,
    output logic [1:0]       pop_color,
    output logic             empty,
    input  logic             discard_load,
    input  logic [2:0]       scx_fine,
    output logic             discarding,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ROW_PIX = CNT_W'(8);
    localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(DEPTH - 8);

    typedef enum logic [1:0] {
        TAKE_NONE,
        TAKE_POP,
        TAKE_DISCARD
    } take_e;

    logic [1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       disc_cnt_q, disc_cnt_d;

    logic             push_acc;
    logic             discard_step;
    take_e            take;
    logic [1:0]       row_pix [8];

    assign push_ready = (count_q <= ROOM_MAX);
    assign discarding = (disc_cnt_q != 3'd0);
    assign empty      = (count_q == '0) || discarding;
    assign pop_color  = empty ? 2'b00 : mem_q[rd_ptr_q];
    assign count      = count_q;

    assign push_acc     = push_valid && push_ready;
    // A discard_load in the same clock wins over a pending discard step.
    assign discard_step = discarding && (count_q != '0) && dot_en && !discard_load;

    always_comb begin
        take = TAKE_NONE;
        if (discard_step) begin
            take = TAKE_DISCARD;
        end else if (pop_en && !empty) begin
            take = TAKE_POP;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row_pix[i] = push_xflip ? {push_hi[i], push_lo[i]}
                                    : {push_hi[7-i], push_lo[7-i]};
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        disc_cnt_d = disc_cnt_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            disc_cnt_d = 3'd0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(8);
            end
            if (take != TAKE_NONE) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (push_acc ? ROW_PIX : '0)
                              - CNT_W'(take != TAKE_NONE);
            if (discard_load) begin
                disc_cnt_d = scx_fine;
            end else if (take == TAKE_DISCARD) begin
                disc_cnt_d = disc_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            disc_cnt_q <= 3'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    // Pixel storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[wr_ptr_q + PTR_W'(i)] <= row_pix[i];
            end
        end
    end

endmodule

// File: tb/tb_ppu_bg_pixel_fifo.sv
// Directed bench for ppu_bg_pixel_fifo: push/pop order, full and wrap,
// fine-scroll discard, flush priority and asynchronous reset.
module tb_ppu_bg_pixel_fifo;

    typedef logic [1:0] pixArr_t [16];

    logic       clk = 1'b0;
    logic       reset;
    logic       dot_en, flush, push_valid, push_xflip, pop_en, discard_load;
    logic [7:0] push_lo, push_hi;
    logic [2:0] scx_fine;
    logic       push_ready, empty, discarding;
    logic [1:0] pop_color;
    logic [4:0] count;

    int cmpCount = 0;
    int errCount = 0;

    ppu_bg_pixel_fifo #(.DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .flush(flush),
        .push_valid(push_valid), .push_lo(push_lo), .push_hi(push_hi),
        .push_xflip(push_xflip), .push_ready(push_ready), .pop_en(pop_en),
        .pop_color(pop_color), .empty(empty), .discard_load(discard_load),
        .scx_fine(scx_fine), .discarding(discarding), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi, input logic xflip);
        push_lo    = lo;
        push_hi    = hi;
        push_xflip = xflip;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic popSeq(input string tag, input int n, input pixArr_t exp);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_pix%0d", tag, i), 32'(pop_color), 32'(exp[i]));
            checkOutput($sformatf("%s_nempty%0d", tag, i), 32'(empty), 32'd0);
            pop_en = 1'b1;
            tick();
        end
        pop_en = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
        checkOutput({tag, "_ready"}, 32'(push_ready), 32'd1);
        checkOutput({tag, "_color"}, 32'(pop_color), 32'd0);
        checkOutput({tag, "_disc"}, 32'(discarding), 32'd0);
    endtask

    initial begin
        int dotPat [5];
        int cntPat [5];
        reset = 1'b1;
        dot_en = 1'b0; flush = 1'b0; push_valid = 1'b0; push_xflip = 1'b0;
        pop_en = 1'b0; discard_load = 1'b0; push_lo = 8'h00; push_hi = 8'h00;
        scx_fine = 3'd0;
        #12;
        checkIdle("reset");
        reset = 1'b0;
        tick();

        // Scenario 1: lo=F0 hi=CC unflipped -> 3,3,1,1,2,2,0,0
        applyStimulus(8'hF0, 8'hCC, 1'b0);
        checkOutput("s1_count", 32'(count), 32'd8);
        checkOutput("s1_empty", 32'(empty), 32'd0);
        popSeq("s1", 8, '{3,3,1,1,2,2,0,0, 0,0,0,0,0,0,0,0});
        checkIdle("s1_end");

        // Scenario 2: x-flipped, only bit 0 set -> first pixel 1
        applyStimulus(8'h01, 8'h00, 1'b1);
        popSeq("s2", 8, '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0});
        checkOutput("s2_empty", 32'(empty), 32'd1);

        // Scenario 3: fill to 16, refused push, then pop+push across the wrap
        applyStimulus(8'hF0, 8'hCC, 1'b0);
        applyStimulus(8'h0F, 8'hAA, 1'b0);
        checkOutput("s3_full_count", 32'(count), 32'd16);
        checkOutput("s3_full_ready", 32'(push_ready), 32'd0);
        applyStimulus(8'h55, 8'h55, 1'b0);
        checkOutput("s3_refused_count", 32'(count), 32'd16);
        popSeq("s3a", 8, '{3,3,1,1,2,2,0,0, 0,0,0,0,0,0,0,0});
        checkOutput("s3_half_count", 32'(count), 32'd8);
        checkOutput("s3_half_ready", 32'(push_ready), 32'd1);
        checkOutput("s3_pp_head", 32'(pop_color), 32'd2);
        pop_en = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        pop_en = 1'b0;
        checkOutput("s3_pp_count", 32'(count), 32'd15);
        popSeq("s3b", 15, '{0,2,0,3,1,3,1, 3,3,3,3,3,3,3,3, 0});
        checkIdle("s3_end");

        // Scenario 4: drop three fine-scroll pixels, dot_en on alternate clocks
        applyStimulus(8'hF0, 8'hCC, 1'b0);
        discard_load = 1'b1;
        scx_fine = 3'd3;
        dot_en = 1'b1;
        tick();
        discard_load = 1'b0;
        checkOutput("s4_load_count", 32'(count), 32'd8);
        checkOutput("s4_load_disc", 32'(discarding), 32'd1);
        checkOutput("s4_load_empty", 32'(empty), 32'd1);
        dotPat = '{1, 0, 1, 0, 1};
        cntPat = '{7, 7, 6, 6, 5};
        pop_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("s4_empty%0d", i), 32'(empty), 32'd1);
            dot_en = dotPat[i][0];
            tick();
            checkOutput($sformatf("s4_count%0d", i), 32'(count), 32'(cntPat[i]));
        end
        dot_en = 1'b0;
        checkOutput("s4_done_disc", 32'(discarding), 32'd0);
        checkOutput("s4_done_empty", 32'(empty), 32'd0);
        checkOutput("s4_first_pix", 32'(pop_color), 32'd1);
        tick();
        pop_en = 1'b0;
        checkOutput("s4_pop_count", 32'(count), 32'd4);
        checkOutput("s4_next_pix", 32'(pop_color), 32'd2);

        // Scenario 5: flush beats push, pop and discard in the same clock
        discard_load = 1'b1;
        scx_fine = 3'd2;
        applyStimulus(8'hFF, 8'h00, 1'b0);
        discard_load = 1'b0;
        checkOutput("s5_pre_count", 32'(count), 32'd12);
        checkOutput("s5_pre_disc", 32'(discarding), 32'd1);
        flush = 1'b1;
        pop_en = 1'b1;
        dot_en = 1'b1;
        applyStimulus(8'hF0, 8'hCC, 1'b0);
        flush = 1'b0;
        pop_en = 1'b0;
        dot_en = 1'b0;
        checkIdle("s5_flush");
        tick();
        checkOutput("s5_after_count", 32'(count), 32'd0);

        // Scenario 6: asynchronous reset between edges during a push
        applyStimulus(8'hF0, 8'hCC, 1'b0);
        checkOutput("s6_pre_count", 32'(count), 32'd8);
        push_lo = 8'h0F; push_hi = 8'hAA; push_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkIdle("s6_async");
        push_valid = 1'b0;
        tick();
        checkIdle("s6_held");
        #2;
        reset = 1'b0;
        tick();
        checkOutput("s6_release_count", 32'(count), 32'd0);
        applyStimulus(8'hF0, 8'hCC, 1'b0);
        checkOutput("s6_count", 32'(count), 32'd8);
        popSeq("s6", 8, '{3,3,1,1,2,2,0,0, 0,0,0,0,0,0,0,0});
        checkIdle("s6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
